fp32_div_iterative: RTL

//  IEEE-754 single-precision divider: the inverse operator to the pipelined FP32 multiplier in the matrix datapath.

---
 rtl/fp32_pkg.sv | 24 ++
 rtl/fp32_div_core.sv | 66 ++++++
 rtl/fp32_div_iterative.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 types and constants for the matrix datapath arithmetic units.
// Latency: n/a (types, constants and enums only).
// Backpressure: n/a.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int          FP32_BIAS    = 127;
  localparam int          FP32_EXP_MAX = 255;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_NORM,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/fp32_div_core.sv
// Restoring mantissa divider: one quotient bit per clock from a 26-bit remainder.
// Latency: load on one edge, then QUOT_BITS step edges; count_done flags the last step cycle.
// Backpressure: none; the owner asserts step only while it wants another quotient bit.
// Ports: clk/rst (sync, active-high), load + ma/mb (24-bit mantissas with hidden one),
//        step (produce one bit), q (quotient, MSB = integer bit), count_done (last step now).
module fp32_div_core #(
  parameter int QUOT_BITS = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [23:0]          ma,
  input  logic [23:0]          mb,
  output logic [QUOT_BITS-1:0] q,
  output logic                 count_done
);

  localparam int CW = $clog2(QUOT_BITS);

  logic [25:0]          rem_q, rem_d;
  logic [23:0]          div_q, div_d;
  logic [QUOT_BITS-1:0] quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [25:0]          diff;
  logic                 q_bit;

  assign diff  = rem_q - {2'b00, div_q};
  assign q_bit = (rem_q >= {2'b00, div_q});

  always_comb begin
    rem_d = rem_q;
    div_d = div_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = {2'b00, ma};
      div_d = mb;
      quo_d = '0;
      cnt_d = '0;
    end else if (step) begin
      // Remainder stays below 2*mb, so the shifted value always fits 26 bits.
      rem_d = (q_bit ? diff : rem_q) << 1;
      quo_d = {quo_q[QUOT_BITS-2:0], q_bit};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign q          = quo_q;
  assign count_done = (cnt_q == CW'(QUOT_BITS - 1));

endmodule

// File: rtl/fp32_div_iterative.sv
// FP32 divider (a/b), truncating, exponent-0 treated as zero, no NaN/subnormal inputs.
// Latency: done is high in the (QUOT_BITS+2)th cycle after the accept edge, constant for all operands.
// Backpressure: start is accepted only while busy==0; a start while busy is dropped, never queued.
// Ports: clk, rst (sync, active-high), start/a/b request; busy, done pulse, result and
//        mutually exclusive overflow/underflow/div_by_zero flags (registered, updated on done).
module fp32_div_iterative
  import fp32_pkg::*;
#(
  parameter int QUOT_BITS   = 25,
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  div_state_e         state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               a_zero_q, a_zero_d;
  logic               b_zero_q, b_zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               dbz_q, dbz_d;

  fp32_t                a_f, b_f;
  logic                 accept;
  logic                 core_step;
  logic                 core_done;
  logic [QUOT_BITS-1:0] quo;
  logic                 quo_int;
  logic [22:0]          mant;
  logic signed [9:0]    e_norm;
  logic [31:0]          res_n;
  logic                 ovf_n, unf_n, dbz_n;

  assign a_f       = a;
  assign b_f       = b;
  assign accept    = (state_q == ST_IDLE) && start;
  assign core_step = (state_q == ST_DIVIDE);

  fp32_div_core #(
    .QUOT_BITS (QUOT_BITS)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .step       (core_step),
    .ma         ({1'b1, a_f.frac}),
    .mb         ({1'b1, b_f.frac}),
    .q          (quo),
    .count_done (core_done)
  );

  // Mantissa ratio lies in (0.5, 2): either the integer bit is set, or the
  // next bit is and the result needs one left shift (exponent minus one).
  assign quo_int = quo[QUOT_BITS-1];
  assign mant    = quo_int ? quo[QUOT_BITS-2 -: 23] : quo[QUOT_BITS-3 -: 23];
  assign e_norm  = quo_int ? exp_q : exp_q - 10'sd1;

  // Special-case table, highest priority first.
  always_comb begin
    res_n = {sign_q, e_norm[7:0], mant};
    ovf_n = 1'b0;
    unf_n = 1'b0;
    dbz_n = 1'b0;
    if (b_zero_q && !a_zero_q) begin
      res_n = {sign_q, FP32_POS_INF[30:0]};
      dbz_n = 1'b1;
    end else if (b_zero_q && a_zero_q) begin
      res_n = FP32_QNAN;
      dbz_n = 1'b1;
    end else if (a_zero_q) begin
      res_n = {sign_q, 31'h0};
    end else if (e_norm >= 10'(FP32_EXP_MAX)) begin
      res_n = {sign_q, FP32_POS_INF[30:0]};
      ovf_n = 1'b1;
    end else if (e_norm <= 10'sd0) begin
      res_n = {sign_q, 31'h0};
      unf_n = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d   = a_f.sign ^ b_f.sign;
          exp_d    = $signed({2'b00, a_f.exp}) - $signed({2'b00, b_f.exp}) + 10'(FP32_BIAS);
          a_zero_d = (a_f.exp == 8'h00);
          b_zero_d = (b_f.exp == 8'h00);
          busy_d   = 1'b1;
          state_d  = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (core_done) state_d = ST_NORM;
      end
      ST_NORM: begin
        result_d = res_n;
        ovf_d    = ovf_n;
        unf_d    = unf_n;
        dbz_d    = dbz_n;
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (!HOLD_RESULT) begin
          result_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          dbz_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule
